psm_wdata_manager: RTL and testbench



---
 rtl/psm_wdata_manager.sv | 138 +++++++++++++
 tb/tb_psm_wdata_manager.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/psm_wdata_manager.sv
// psm_wdata_manager: write-side partial-sum scatter.
// Pops Y-element words from an FWFT FIFO and places the elements, in row
// order, onto the masked lanes of the SRAM write bus. Elements of a popped
// word that are not needed yet are held and used first by the next request.
//
// Handshake: a request (i_req=1 with a non-zero i_mask) is accepted in the
// cycle it is presented unless o_stall=1; while stalled, upstream keeps
// i_req/i_mask stable. o_fifo_pop is a combinational FWFT pop that consumes
// the current head in that same cycle. Write outputs follow one cycle later.
module psm_wdata_manager #(
  parameter int Y       = 3,
  parameter int OC_W    = 48,
  parameter int SRAMC_N = 2,
  parameter int SRAMC_W = 96,
  parameter int BUFF_W  = 144
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [BUFF_W-1:0]  i_fifo_dout,
  input  logic               i_fifo_empty,
  output logic               o_fifo_pop,
  input  logic [0:Y-1]       i_rows_active,
  input  logic               i_en,
  input  logic               i_clearbuff,
  input  logic               i_req,
  input  logic [0:SRAMC_N-1] i_mask,
  output logic               o_stall,
  output logic               o_sramc_wren,
  output logic [0:SRAMC_N-1] o_sramc_wmask,
  output logic [SRAMC_W-1:0] o_sramc_data,
  output logic               o_hold_empty
);

  logic [OC_W-1:0]    hold_q [Y];
  logic [OC_W-1:0]    hold_d [Y];
  logic [0:Y-1]       pend_q, pend_d;
  logic               wren_q, wren_d;
  logic [0:SRAMC_N-1] wmask_q, wmask_d;
  logic [SRAMC_W-1:0] data_q, data_d;

  // Request decode, serviceability and element-to-lane scatter.
  always_comb begin : scatter_p
    int                 n_cnt;
    int                 p_cnt;
    int                 k;
    int                 r;
    int                 lane_rank [SRAMC_N];
    logic [0:Y-1]       head_used;
    logic               use_head;
    logic [SRAMC_W-1:0] wdata;

    pend_d     = pend_q;
    hold_d     = hold_q;
    wren_d     = 1'b0;
    wmask_d    = wmask_q;
    data_d     = data_q;
    o_stall    = 1'b0;
    o_fifo_pop = 1'b0;
    n_cnt      = 0;
    p_cnt      = 0;
    k          = 0;
    r          = 0;
    head_used  = '0;
    use_head   = 1'b0;
    wdata      = '0;
    for (int i = 0; i < SRAMC_N; i++) lane_rank[i] = 0;

    for (int i = 0; i < SRAMC_N; i++) if (i_mask[i]) n_cnt++;
    for (int c = 0; c < Y; c++) if (pend_q[c]) p_cnt++;

    // Map the r-th set mask bit (ascending lane) to its lane index.
    for (int i = 0; i < SRAMC_N; i++) begin
      if (i_mask[i]) begin
        lane_rank[r] = i;
        r++;
      end
    end

    if (i_clearbuff) begin
      pend_d = '0;
    end else if (i_en && i_req && (n_cnt > 0)) begin
      if ((n_cnt > p_cnt) && i_fifo_empty) begin
        o_stall = 1'b1;
      end else begin
        // Held elements go out first, oldest row first.
        for (int c = 0; c < Y; c++) begin
          if (pend_q[c] && (k < n_cnt)) begin
            wdata[lane_rank[k]*OC_W +: OC_W] = hold_q[c];
            pend_d[c] = 1'b0;
            k++;
          end
        end
        // Then the active rows of the FIFO head.
        for (int j = 0; j < Y; j++) begin
          if (i_rows_active[j] && !i_fifo_empty && (k < n_cnt)) begin
            wdata[lane_rank[k]*OC_W +: OC_W] = i_fifo_dout[j*OC_W +: OC_W];
            head_used[j] = 1'b1;
            use_head     = 1'b1;
            k++;
          end
        end
        // Touching the head means all held elements were consumed, so the
        // hold register is simply reloaded with the leftover head elements.
        if (use_head) begin
          o_fifo_pop = 1'b1;
          for (int j = 0; j < Y; j++) hold_d[j] = i_fifo_dout[j*OC_W +: OC_W];
          pend_d = i_rows_active & ~head_used;
        end
        wren_d  = 1'b1;
        wmask_d = i_mask;
        data_d  = wdata;
      end
    end
  end

  // State and registered write outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_q  <= '0;
      wren_q  <= 1'b0;
      wmask_q <= '0;
      data_q  <= '0;
      for (int j = 0; j < Y; j++) hold_q[j] <= '0;
    end else begin
      pend_q  <= pend_d;
      wren_q  <= wren_d;
      wmask_q <= wmask_d;
      data_q  <= data_d;
      for (int j = 0; j < Y; j++) hold_q[j] <= hold_d[j];
    end
  end

  assign o_sramc_wren  = wren_q;
  assign o_sramc_wmask = wmask_q;
  assign o_sramc_data  = data_q;
  assign o_hold_empty  = (pend_q == '0);

endmodule

// File: tb/tb_psm_wdata_manager.sv
// Directed bench for psm_wdata_manager with an FWFT FIFO model, an
// element-queue reference model and a scoreboard of expected writes.
module tb_psm_wdata_manager;

  localparam int Y       = 3;
  localparam int OC_W    = 48;
  localparam int SRAMC_N = 2;
  localparam int SRAMC_W = 96;
  localparam int BUFF_W  = 144;
  localparam int EW      = SRAMC_N + SRAMC_W;

  logic               i_clk;
  logic               i_rstn;
  logic [BUFF_W-1:0]  i_fifo_dout;
  logic               i_fifo_empty;
  logic               o_fifo_pop;
  logic [0:Y-1]       i_rows_active;
  logic               i_en;
  logic               i_clearbuff;
  logic               i_req;
  logic [0:SRAMC_N-1] i_mask;
  logic               o_stall;
  logic               o_sramc_wren;
  logic [0:SRAMC_N-1] o_sramc_wmask;
  logic [SRAMC_W-1:0] o_sramc_data;
  logic               o_hold_empty;

  psm_wdata_manager #(
    .Y(Y), .OC_W(OC_W), .SRAMC_N(SRAMC_N), .SRAMC_W(SRAMC_W), .BUFF_W(BUFF_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_fifo_dout   (i_fifo_dout),
    .i_fifo_empty  (i_fifo_empty),
    .o_fifo_pop    (o_fifo_pop),
    .i_rows_active (i_rows_active),
    .i_en          (i_en),
    .i_clearbuff   (i_clearbuff),
    .i_req         (i_req),
    .i_mask        (i_mask),
    .o_stall       (o_stall),
    .o_sramc_wren  (o_sramc_wren),
    .o_sramc_wmask (o_sramc_wmask),
    .o_sramc_data  (o_sramc_data),
    .o_hold_empty  (o_hold_empty)
  );

  // Clock and reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [BUFF_W-1:0] fifo_q [$];
  logic [OC_W-1:0]   held   [$];
  logic [EW-1:0]     exp_q  [$];
  logic [EW-1:0]     last_wr;
  int                checks;
  int                passed;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic refresh_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word();
    logic [BUFF_W-1:0] w;
    logic [OC_W-1:0]   e;
    for (int j = 0; j < Y; j++) begin
      e = {16'($urandom_range(0, 65535)), 32'($urandom)};
      w[j*OC_W +: OC_W] = e;
    end
    fifo_q.push_back(w);
    refresh_fifo();
  endtask

  // Driver + reference model for one clock cycle.
  task automatic step(input logic req, input logic [0:SRAMC_N-1] mask,
                      input logic [0:Y-1] rows, input logic en, input logic clr,
                      input string tag);
    int                 n;
    logic               e_stall, e_pop, e_wr;
    logic [OC_W-1:0]    lst [$];
    logic [SRAMC_W-1:0] wd;
    logic [BUFF_W-1:0]  head;
    logic [EW-1:0]      exp;
    @(negedge i_clk);
    i_req = req; i_mask = mask; i_rows_active = rows; i_en = en; i_clearbuff = clr;
    n = 0;
    for (int i = 0; i < SRAMC_N; i++) if (mask[i]) n++;
    e_stall = 1'b0; e_pop = 1'b0; e_wr = 1'b0; wd = '0;
    lst = held;
    if (!clr && en && req && n > 0) begin
      if (n > held.size()) begin
        if (fifo_q.size() == 0) e_stall = 1'b1;
        else begin
          e_pop = 1'b1;
          head  = fifo_q[0];
          for (int j = 0; j < Y; j++) if (rows[j]) lst.push_back(head[j*OC_W +: OC_W]);
        end
      end
      if (!e_stall) begin
        e_wr = 1'b1;
        for (int i = 0; i < SRAMC_N; i++) if (mask[i]) wd[i*OC_W +: OC_W] = lst.pop_front();
        exp_q.push_back({mask, wd});
      end
    end
    #1;
    chk({tag, ".stall"}, 128'(o_stall), 128'(e_stall));
    chk({tag, ".pop"}, 128'(o_fifo_pop), 128'(e_pop));
    @(posedge i_clk);
    #1;
    if (e_pop) begin
      void'(fifo_q.pop_front());
      refresh_fifo();
    end
    if (clr) held.delete();
    else if (e_wr) held = lst;
    chk({tag, ".wren"}, 128'(o_sramc_wren), 128'(e_wr));
    if (e_wr && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk({tag, ".wdata"}, 128'({o_sramc_wmask, o_sramc_data}), 128'(exp));
      last_wr = exp;
    end else begin
      chk({tag, ".hold_regs"}, 128'({o_sramc_wmask, o_sramc_data}), 128'(last_wr));
    end
    chk({tag, ".hold_empty"}, 128'(o_hold_empty), 128'(held.size() == 0));
  endtask

  initial begin
    checks = 0; passed = 0; last_wr = '0;
    i_rstn = 1'b1; i_req = 1'b0; i_mask = '0; i_rows_active = '1;
    i_en = 1'b1; i_clearbuff = 1'b0;
    refresh_fifo();
    #1 i_rstn = 1'b0;
    #1;
    chk("rst.wren", 128'(o_sramc_wren), 128'(0));
    chk("rst.wmask", 128'(o_sramc_wmask), 128'(0));
    chk("rst.data", 128'(o_sramc_data), 128'(0));
    chk("rst.hold_empty", 128'(o_hold_empty), 128'(1));
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;

    // Full rows, mask 11, A then B in the FIFO
    push_word(); push_word();
    step(1, 2'b11, 3'b111, 1, 0, "full_a");
    step(1, 2'b11, 3'b111, 1, 0, "full_b");
    step(1, 2'b11, 3'b111, 1, 0, "full_held");
    step(0, 2'b11, 3'b111, 1, 0, "idle");

    // Mask 01: lane1 gets A0, lane0 zero
    push_word();
    step(1, 2'b01, 3'b111, 1, 0, "m01_a");
    step(1, 2'b00, 3'b111, 1, 0, "mask0_noreq");
    step(1, 2'b01, 3'b111, 1, 0, "m01_held");
    step(1, 2'b10, 3'b111, 1, 0, "m10_held");

    // Pending A2 only, FIFO empty: stall until B arrives
    push_word();
    step(1, 2'b11, 3'b111, 1, 0, "pre_stall");
    step(1, 2'b11, 3'b111, 1, 0, "stall1");
    step(1, 2'b11, 3'b111, 1, 0, "stall2");
    push_word();
    step(1, 2'b11, 3'b111, 1, 0, "unstall");

    // Clearbuff with a request discards held B1,B2
    push_word();
    step(1, 2'b11, 3'b111, 1, 1, "clear_req");
    step(1, 2'b11, 3'b111, 1, 0, "after_clear");
    step(0, 2'b00, 3'b111, 0, 1, "clear_en0");

    // Sparse rows 101
    push_word();
    step(1, 2'b11, 3'b101, 1, 0, "rows101");

    // Enable low for 3 cycles with a request pending
    push_word();
    step(1, 2'b11, 3'b111, 0, 0, "en0_1");
    step(1, 2'b11, 3'b111, 0, 0, "en0_2");
    step(1, 2'b11, 3'b111, 0, 0, "en0_3");
    step(1, 2'b11, 3'b111, 1, 0, "en1");

    // Asynchronous reset with A2 held and B in the FIFO
    push_word();
    @(negedge i_clk);
    i_req = 1'b0;
    #2 i_rstn = 1'b0;
    #1;
    held.delete(); exp_q.delete(); last_wr = '0;
    chk("arst.wren", 128'(o_sramc_wren), 128'(0));
    chk("arst.wmask", 128'(o_sramc_wmask), 128'(0));
    chk("arst.data", 128'(o_sramc_data), 128'(0));
    chk("arst.hold_empty", 128'(o_hold_empty), 128'(1));
    chk("arst.pop", 128'(o_fifo_pop), 128'(0));
    @(negedge i_clk);
    i_rstn = 1'b1;
    step(1, 2'b11, 3'b111, 1, 0, "post_rst");

    // Random masks over a stocked FIFO
    for (int it = 0; it < 12; it++) begin
      if (fifo_q.size() < 2) push_word();
      step(1, 2'($urandom_range(1, 3)), 3'b111, 1, 0, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
